encryption_top: RTL and testbench

- Pipelined 64-bit block encryptor with an 80-bit key, sitting on the 64-bit data / 8-bit ctrl packet stream between an upstream source and a downstream sink.
- Each accepted data word is split into four 16-bit words and passed through ROUNDS registered round stages.
- Control words (ctrl != 0) pass through unencrypted with the same latency, so stream order is preserved.

---
 rtl/encryption_top.sv | 83 ++++++++
 tb/tb_encryption_top.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/encryption_top.sv
`default_nettype none
// ============================================================================
// Module   : encryption_top
// Purpose  : ROUNDS-stage pipelined 64-bit block encryptor (80-bit key) on a
//            data/ctrl packet stream; ctrl words bypass the cipher in order.
// Revision : 1.0 - initial release
// ============================================================================
module encryption_top #(
    parameter int ROUNDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_ctrl,
    input  logic        in_wr,
    output logic        in_rdy,
    input  logic [79:0] key,
    output logic [63:0] out_data,
    output logic [7:0]  out_ctrl,
    output logic        out_wr,
    input  logic        out_rdy
);

    logic [ROUNDS-1:0]       valid_q, valid_d;
    logic [ROUNDS-1:0][63:0] data_q,  data_d;
    logic [ROUNDS-1:0][7:0]  ctrl_q,  ctrl_d;
    logic                    adv;

    function automatic logic [15:0] round_key(input logic [79:0] k, input int r);
        case (r % 5)
            0:       return k[79:64];
            1:       return k[63:48];
            2:       return k[47:32];
            3:       return k[31:16];
            default: return k[15:0];
        endcase
    endfunction

    // One round on d0..d3: shift words left, new d3 = ((d0^K)+d1)^d3.
    function automatic logic [63:0] round_f(input logic [63:0] d,
                                            input logic [7:0]  c,
                                            input logic [15:0] k);
        logic [15:0] t;
        t = ((d[63:48] ^ k) + d[47:32]) ^ d[15:0];
        return (c == 8'd0) ? {d[47:0], t} : d;
    endfunction

    // The whole pipeline moves as one unit; a bubble at the tail lets it advance.
    assign adv    = out_rdy | ~valid_q[ROUNDS-1];
    assign in_rdy = adv;

    always_comb begin
        valid_d    = '0;
        data_d     = '0;
        ctrl_d     = '0;
        valid_d[0] = in_wr & adv;
        data_d[0]  = round_f(in_data, in_ctrl, round_key(key, 0));
        ctrl_d[0]  = in_ctrl;
        for (int r = 1; r < ROUNDS; r++) begin
            valid_d[r] = valid_q[r-1];
            data_d[r]  = round_f(data_q[r-1], ctrl_q[r-1], round_key(key, r));
            ctrl_d[r]  = ctrl_q[r-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_wr   = valid_q[ROUNDS-1];
    assign out_data = data_q[ROUNDS-1];
    assign out_ctrl = ctrl_q[ROUNDS-1];

endmodule
`default_nettype wire

// File: tb/tb_encryption_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_encryption_top
// Purpose  : Self-checking bench for encryption_top: known answers, streaming,
//            backpressure, reset and randomized traffic against a word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encryption_top;

    localparam int ROUNDS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [79:0] key;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;

    int n_pass  = 0;
    int n_total = 0;
    int n_acc   = 0;
    int n_out   = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  expc_q[$];

    encryption_top #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .key      (key),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy)
    );

    always #5 clk = ~clk;

    // Word-level reference: split into four 16-bit words and apply the round rule.
    function automatic logic [63:0] model(input logic [63:0] d, input logic [7:0] c,
                                          input logic [79:0] k);
        logic [15:0] w[4];
        logic [15:0] ks[5];
        logic [15:0] t;
        if (c != 8'd0) return d;
        for (int i = 0; i < 4; i++) w[i] = d[63-16*i -: 16];
        for (int i = 0; i < 5; i++) ks[i] = k[79-16*i -: 16];
        for (int r = 0; r < ROUNDS; r++) begin
            t    = ((w[0] ^ ks[r % 5]) + w[1]) ^ w[3];
            w[0] = w[1];
            w[1] = w[2];
            w[2] = w[3];
            w[3] = t;
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: outputs are matched against words in acceptance order.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_wr && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("out_ctrl", 64'(out_ctrl), 64'(expc_q.pop_front()));
                end
                n_out++;
            end
            if (in_wr && in_rdy) begin
                exp_q.push_back(model(in_data, in_ctrl, key));
                expc_q.push_back(in_ctrl);
                n_acc++;
            end
        end
    end

    task automatic kat(input string tag, input logic [79:0] k, input logic [63:0] d,
                       input logic [7:0] c, input logic [63:0] exp_d);
        key     = k;
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        out_rdy = 1'b1;
        step();
        in_wr = 1'b0;
        repeat (ROUNDS - 2) step();
        check({tag, "_early"}, 64'(out_wr), 64'd0);
        step();
        check({tag, "_wr"},   64'(out_wr), 64'd1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_ctrl"}, 64'(out_ctrl), 64'(c));
        step();
        check({tag, "_pulse"}, 64'(out_wr), 64'd0);
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit rand_rdy);
        bit acc;
        acc     = 1'b0;
        in_wr   = 1'b1;
        in_data = d;
        in_ctrl = c;
        for (int w = 0; w < 64 && !acc; w++) begin
            if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
            #1;
            acc = in_rdy;
            step();
        end
        in_wr = 1'b0;
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = 1'b0;
        key     = '0;
        out_rdy = 1'b1;
        #12;
        check("rst_out_wr",   64'(out_wr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_in_rdy",   64'(in_rdy), 64'd1);
        step();
        reset = 1'b0;
        step();

        kat("kat1",  80'h0123_4567_89ab_cdef_0123, 64'h1123_4567_89ab_cdef, 8'h00,
            64'h9888_1123_dccc_4444);
        kat("kat0a", 80'h0, 64'h0000_0001_0000_0000, 8'h00, 64'h0001_0000_0000_0001);
        kat("kat0b", 80'h0, 64'h0, 8'h00, 64'h0);
        kat("pass",  80'h0123_4567_89ab_cdef_0123, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF,
            64'hDEAD_BEEF_CAFE_F00D);

        // Back-to-back burst: header then seven payload words, no stalls.
        key     = {16'($urandom), $urandom, $urandom};
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_wr   = 1'b1;
            in_ctrl = (i == 0) ? 8'hFF : 8'h00;
            in_data = {$urandom, $urandom};
            step();
            if (i >= ROUNDS - 1) check("burst_wr", 64'(out_wr), 64'd1);
        end
        in_wr = 1'b0;
        repeat (ROUNDS - 1) begin
            step();
            check("burst_wr_tail", 64'(out_wr), 64'd1);
        end
        step();
        check("burst_end", 64'(out_wr), 64'd0);
        check("burst_count", 64'(n_out), 64'(n_acc));

        // Backpressure: fill the pipeline against a stalled sink.
        key     = {16'($urandom), $urandom, $urandom};
        out_rdy = 1'b0;
        for (int i = 0; i < ROUNDS; i++) send_word({$urandom, $urandom}, 8'h00, 1'b0);
        check("bp_in_rdy", 64'(in_rdy), 64'd0);
        check("bp_out_wr", 64'(out_wr), 64'd1);
        in_wr   = 1'b1;
        in_data = 64'h0F0F_1234_5678_9ABC;
        in_ctrl = 8'h00;
        repeat (3) begin
            step();
            check("bp_hold_rdy",  64'(in_rdy), 64'd0);
            check("bp_hold_wr",   64'(out_wr), 64'd1);
            check("bp_hold_data", out_data, exp_q[0]);
            check("bp_hold_ctrl", 64'(out_ctrl), 64'(expc_q[0]));
        end
        check("bp_depth", 64'(exp_q.size()), 64'(ROUNDS));
        out_rdy = 1'b1;
        send_word(64'h0F0F_1234_5678_9ABC, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 8'h00, 1'b1);
        out_rdy = 1'b1;
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) step();
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_count",   64'(n_out), 64'(n_acc));

        // Reset mid-stream discards everything immediately.
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 8'h00, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_wr",   64'(out_wr), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_rdy",  64'(in_rdy), 64'd1);
        exp_q.delete();
        expc_q.delete();
        n_acc = 0;
        n_out = 0;
        step();
        reset = 1'b0;
        step();

        // Randomized traffic with a randomly stalling sink.
        key = {16'($urandom), $urandom, $urandom};
        for (int i = 0; i < 60; i++)
            send_word({$urandom, $urandom},
                      ($urandom_range(0, 3) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00,
                      1'b1);
        out_rdy = 1'b1;
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) step();
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_count",   64'(n_out), 64'(n_acc));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
